sprite_layer_compositor: RTL and testbench
==========================================

# sprite_layer_compositor

Parametrised N-layer sprite compositor with a two-stage registered pipeline, placed between the per-part sprite blocks (head, body, arms, pants, …) and the VGA colour mux. The highest-index visible layer wins each pixel. Adds runtime per-layer enable and flash masks, applied tear-free at frame boundaries, plus a per-frame count of overlap (collision) pixels for the motion/vision logic.

## Interface
Parameters:
- NUM_LAYERS, 5, number of sprite layers; index NUM_LAYERS-1 has highest priority
- COLOR_W, 8, bits per colour channel
- CNT_W, 19, collision counter width (covers 640x480)
- FLASH_DIV, 4, flash phase toggles every 2^(FLASH_DIV-1) frames

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  pipeline advance; low = hold all state
- iFrameStart  in  1  one-cycle pulse aligned with the first pixel of a frame
- iLayerVal  in  NUM_LAYERS  per-layer pixel-valid
- iR, iG, iB  in  NUM_LAYERS*COLOR_W each  packed colours; layer k at bits [k*COLOR_W +: COLOR_W]
- cfg_we  in  1  load shadow config
- cfg_layer_en  in  NUM_LAYERS  layer enable mask
- cfg_flash_mask  in  NUM_LAYERS  layers hidden during flash phase
- oVal  out  1  some layer drawn at this pixel
- oR, oG, oB  out  COLOR_W each  composited colour; 0 when oVal=0
- oCollide  out  1  two or more effective layers valid at this pixel
- oCollideCount  out  CNT_W  collision pixels of the previous frame
- oCountValid  out  1  one-cycle pulse when oCollideCount updates

## Operation
- Config: cfg_we copies cfg_layer_en/cfg_flash_mask into shadow registers. Active registers load from shadow on iFrameStart (enable high). cfg_we coinciding with iFrameStart: the new cfg values go straight to active that cycle and are used from that frame's first pixel.
- Reset values: active layer_en = all ones, flash_mask = 0, shadow same; frame counter 0; flash_phase 0.
- Flash: FLASH_DIV-bit frame counter increments (wraps) on each iFrameStart; flash_phase = counter MSB.
- Stage 1 (registered): eff = iLayerVal & layer_en & ~(flash_mask & {NUM_LAYERS{flash_phase}}); register eff, all colours, and coll = (popcount(eff) >= 2). Masks used are those active in the same cycle (after any frame-start load).
- Stage 2 (registered): MSB-priority select over eff; oVal = |eff; colour of winning layer, else 0; oCollide = coll.
- Collision accumulator: counts stage-1 coll, saturating at 2^CNT_W-1. On iFrameStart: oCollideCount <= accumulator (previous frame total), accumulator <= contribution of the current pixel (0 or 1), oCountValid pulses at stage-2 timing.
- enable low: no register changes except config shadow (cfg_we still honoured); iFrameStart ignored.

## Timing
- Pixel latency: 2 enabled cycles, input at edge n -> oVal/oR/oG/oB/oCollide valid after edge n+2.
- oCollideCount and oCountValid appear 2 enabled cycles after iFrameStart, aligned with the first composited pixel of the new frame; oCountValid otherwise 0.
- Reset (asynchronous, mid-frame included): all pipeline registers, oVal, oR/oG/oB, oCollide, oCountValid, oCollideCount = 0; accumulator 0; config to reset values. First output after reset release appears 2 enabled cycles later.
- NUM_LAYERS=1: oCollide always 0.

## Test plan
- Priority: layers 1 and 3 valid with R=0x11, 0x33 -> two cycles later oVal=1, oR=0x33, oCollide=1; no layer valid -> oVal=0, RGB=0.
- Masking: cfg_we with layer_en=5'b10111 mid-frame -> layer 3 still drawn until next iFrameStart, then layer 1 colour 0x11 wins.
- Flash: FLASH_DIV=2, flash_mask=5'b10000, layer 4 valid every frame -> visible frames 0,1, hidden frames 2,3, visible 4,5.
- Collision count: 100 overlap pixels in frame A, then iFrameStart -> oCollideCount=100, oCountValid one pulse 2 cycles after; overlap on the frame-start pixel itself counts toward the next frame.
- Saturation and stall: CNT_W=4, 20 overlap pixels -> count 15; enable low for 3 cycles mid-stream -> outputs hold, resume with no lost or duplicated pixel.
- Reset mid-frame: assert reset with oVal=1 -> all outputs 0 immediately; config back to all-enabled, no flash.

Source files
------------

// File: rtl/sprite_layer_compositor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sprite_layer_compositor : N-layer priority compositor, 2-stage pipeline,
// frame-synchronous enable/flash masks and per-frame collision count. rev 1.0
// ----------------------------------------------------------------------------
module sprite_layer_compositor #(
  parameter int NUM_LAYERS = 5,
  parameter int COLOR_W    = 8,
  parameter int CNT_W      = 19,
  parameter int FLASH_DIV  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          iFrameStart,
  input  logic [NUM_LAYERS-1:0]         iLayerVal,
  input  logic [NUM_LAYERS*COLOR_W-1:0] iR,
  input  logic [NUM_LAYERS*COLOR_W-1:0] iG,
  input  logic [NUM_LAYERS*COLOR_W-1:0] iB,
  input  logic                          cfg_we,
  input  logic [NUM_LAYERS-1:0]         cfg_layer_en,
  input  logic [NUM_LAYERS-1:0]         cfg_flash_mask,
  output logic                          oVal,
  output logic [COLOR_W-1:0]            oR,
  output logic [COLOR_W-1:0]            oG,
  output logic [COLOR_W-1:0]            oB,
  output logic                          oCollide,
  output logic [CNT_W-1:0]              oCollideCount,
  output logic                          oCountValid
);

  localparam int PIX_W = NUM_LAYERS * COLOR_W;

  logic [NUM_LAYERS-1:0] shadow_en, shadow_flash, active_en, active_flash;
  logic [FLASH_DIV-1:0]  frame_cnt;
  logic                  flash_phase;
  logic                  frame_go;
  logic [NUM_LAYERS-1:0] cur_en, cur_flash, eff_now;
  logic                  cur_phase, coll_now, seen_one;

  logic [NUM_LAYERS-1:0] eff_s1;
  logic [PIX_W-1:0]      r_s1, g_s1, b_s1;
  logic                  coll_s1, frame_s1;
  logic [CNT_W-1:0]      acc, snap_s1;
  logic [COLOR_W-1:0]    sel_r, sel_g, sel_b;

  assign frame_go = enable & iFrameStart;

  // The frame-start pixel already sees the masks and phase of its own frame.
  always_comb begin
    cur_en    = active_en;
    cur_flash = active_flash;
    cur_phase = flash_phase;
    if (frame_go) begin
      cur_en    = cfg_we ? cfg_layer_en   : shadow_en;
      cur_flash = cfg_we ? cfg_flash_mask : shadow_flash;
      cur_phase = frame_cnt[FLASH_DIV-1];
    end
    eff_now = iLayerVal & cur_en & ~(cur_flash & {NUM_LAYERS{cur_phase}});
  end

  always_comb begin
    seen_one = 1'b0;
    coll_now = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (eff_now[k]) begin
        if (seen_one) coll_now = 1'b1;
        seen_one = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_en    <= '1;
      shadow_flash <= '0;
    end else if (cfg_we) begin
      shadow_en    <= cfg_layer_en;
      shadow_flash <= cfg_flash_mask;
    end
  end

  // flash_phase holds the counter value sampled at the start of the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_en    <= '1;
      active_flash <= '0;
      flash_phase  <= 1'b0;
      frame_cnt    <= '0;
    end else if (frame_go) begin
      active_en    <= cur_en;
      active_flash <= cur_flash;
      flash_phase  <= cur_phase;
      frame_cnt    <= frame_cnt + FLASH_DIV'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eff_s1   <= '0;
      r_s1     <= '0;
      g_s1     <= '0;
      b_s1     <= '0;
      coll_s1  <= 1'b0;
      frame_s1 <= 1'b0;
      acc      <= '0;
      snap_s1  <= '0;
    end else if (enable) begin
      eff_s1   <= eff_now;
      r_s1     <= iR;
      g_s1     <= iG;
      b_s1     <= iB;
      coll_s1  <= coll_now;
      frame_s1 <= iFrameStart;
      if (iFrameStart) begin
        snap_s1 <= acc;
        acc     <= CNT_W'(coll_now);
      end else if (coll_now && (acc != {CNT_W{1'b1}})) begin
        acc <= acc + CNT_W'(1);
      end
    end
  end

  // Ascending scan: the highest-index valid layer overwrites the rest.
  always_comb begin
    sel_r = '0;
    sel_g = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (eff_s1[k]) begin
        sel_r = r_s1[k*COLOR_W +: COLOR_W];
        sel_g = g_s1[k*COLOR_W +: COLOR_W];
        sel_b = b_s1[k*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oVal          <= 1'b0;
      oR            <= '0;
      oG            <= '0;
      oB            <= '0;
      oCollide      <= 1'b0;
      oCountValid   <= 1'b0;
      oCollideCount <= '0;
    end else if (enable) begin
      oVal        <= |eff_s1;
      oR          <= sel_r;
      oG          <= sel_g;
      oB          <= sel_b;
      oCollide    <= coll_s1;
      oCountValid <= frame_s1;
      if (frame_s1) oCollideCount <= snap_s1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_compositor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sprite_layer_compositor : directed checks of priority, masking, flash,
// collision counting, saturation, stall and asynchronous reset. rev 1.0
// ----------------------------------------------------------------------------
module tb_sprite_layer_compositor;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        iFrameStart;
  logic [4:0]  iLayerVal;
  logic [39:0] iR, iG, iB;
  logic        cfg_we;
  logic [4:0]  cfg_layer_en, cfg_flash_mask;

  logic        val_a, coll_a, cv_a, val_b, coll_b, cv_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [18:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks   = 0;
  int failures = 0;

  sprite_layer_compositor #(.NUM_LAYERS(5), .COLOR_W(8), .CNT_W(19), .FLASH_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .iFrameStart(iFrameStart),
    .iLayerVal(iLayerVal), .iR(iR), .iG(iG), .iB(iB),
    .cfg_we(cfg_we), .cfg_layer_en(cfg_layer_en), .cfg_flash_mask(cfg_flash_mask),
    .oVal(val_a), .oR(r_a), .oG(g_a), .oB(b_a), .oCollide(coll_a),
    .oCollideCount(cnt_a), .oCountValid(cv_a)
  );

  sprite_layer_compositor #(.NUM_LAYERS(5), .COLOR_W(8), .CNT_W(4), .FLASH_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .iFrameStart(iFrameStart),
    .iLayerVal(iLayerVal), .iR(iR), .iG(iG), .iB(iB),
    .cfg_we(cfg_we), .cfg_layer_en(cfg_layer_en), .cfg_flash_mask(cfg_flash_mask),
    .oVal(val_b), .oR(r_b), .oG(g_b), .oB(b_b), .oCollide(coll_b),
    .oCollideCount(cnt_b), .oCountValid(cv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one pixel, then step past the capturing edge.
  task automatic px(input logic fs, input logic [4:0] v);
    iFrameStart = fs;
    iLayerVal   = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; iFrameStart = 1'b0; iLayerVal = '0;
    cfg_we = 1'b0; cfg_layer_en = '0; cfg_flash_mask = '0;
    // layer k: R = 0x11*k, G = 0x10+k, B = 0xA0+k
    for (int k = 0; k < 5; k++) begin
      iR[k*8 +: 8] = 8'(8'h11 * k);
      iG[k*8 +: 8] = 8'(8'h10 + k);
      iB[k*8 +: 8] = 8'(8'hA0 + k);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_val", {31'd0, val_a}, 32'd0);
    check("rst_cnt", {13'd0, cnt_a}, 32'd0);
    check("rst_cv", {31'd0, cv_a}, 32'd0);
    reset = 1'b1;

    // priority and latency
    px(1'b0, 5'b01010);
    check("lat_not_yet", {31'd0, val_a}, 32'd0);
    px(1'b0, 5'b00000);
    check("pri_val", {31'd0, val_a}, 32'd1);
    check("pri_r", {24'd0, r_a}, 32'h33);
    check("pri_g", {24'd0, g_a}, 32'h13);
    check("pri_b", {24'd0, b_a}, 32'hA3);
    check("pri_coll", {31'd0, coll_a}, 32'd1);
    px(1'b0, 5'b00000);
    check("none_val", {31'd0, val_a}, 32'd0);
    check("none_r", {24'd0, r_a}, 32'd0);
    check("none_coll", {31'd0, coll_a}, 32'd0);

    // frame 0 starts; pre-frame overlap (1 pixel) is reported
    px(1'b1, 5'b00000);
    check("cv_early", {31'd0, cv_a}, 32'd0);
    px(1'b0, 5'b00000);
    check("cv_f0", {31'd0, cv_a}, 32'd1);
    check("cnt_f0", {13'd0, cnt_a}, 32'd1);

    // masking: shadow load mid-frame, applied at next frame start
    cfg_we = 1'b1; cfg_layer_en = 5'b10111; cfg_flash_mask = 5'b00000;
    px(1'b0, 5'b00000);
    cfg_we = 1'b0;
    check("cv_pulse_once", {31'd0, cv_a}, 32'd0);
    px(1'b0, 5'b01010);
    px(1'b0, 5'b00000);
    check("mask_hold_r", {24'd0, r_a}, 32'h33);
    px(1'b1, 5'b01010);
    px(1'b0, 5'b00000);
    check("mask_new_r", {24'd0, r_a}, 32'h11);
    check("mask_new_coll", {31'd0, coll_a}, 32'd0);
    check("cnt_f1", {13'd0, cnt_a}, 32'd1);

    // flash: frame 2 with immediate cfg load, hidden frames 2,3, visible 4,5
    cfg_we = 1'b1; cfg_layer_en = 5'b11111; cfg_flash_mask = 5'b10000;
    px(1'b1, 5'b10000);
    cfg_we = 1'b0;
    px(1'b0, 5'b10000);
    check("flash_f2_start", {31'd0, val_a}, 32'd0);
    check("cnt_f2", {13'd0, cnt_a}, 32'd0);
    px(1'b1, 5'b10000);
    check("flash_f2_mid", {31'd0, val_a}, 32'd0);
    px(1'b0, 5'b10000);
    check("flash_f3", {31'd0, val_a}, 32'd0);
    px(1'b1, 5'b10000);
    px(1'b0, 5'b10000);
    check("flash_f4_val", {31'd0, val_a}, 32'd1);
    check("flash_f4_r", {24'd0, r_a}, 32'h44);
    px(1'b1, 5'b10000);
    px(1'b0, 5'b00000);
    check("flash_f5_val", {31'd0, val_a}, 32'd1);

    // collision count: 100 overlap pixels, then frame start with overlap
    for (int i = 0; i < 100; i++) px(1'b0, 5'b00011);
    px(1'b1, 5'b00011);
    check("cnt_cv_lat", {31'd0, cv_a}, 32'd0);
    px(1'b0, 5'b00000);
    check("cnt_cv", {31'd0, cv_a}, 32'd1);
    check("cnt_100", {13'd0, cnt_a}, 32'd100);
    check("cnt_sat", {28'd0, cnt_b}, 32'd15);
    check("cnt_cv_b", {31'd0, cv_b}, 32'd1);
    check("fs_pix_coll", {31'd0, coll_a}, 32'd1);
    check("fs_pix_r", {24'd0, r_a}, 32'h11);
    px(1'b0, 5'b00000);
    check("cnt_cv_off", {31'd0, cv_a}, 32'd0);
    px(1'b1, 5'b00000);
    px(1'b0, 5'b00000);
    check("cnt_carry", {13'd0, cnt_a}, 32'd1);
    check("cnt_carry_b", {28'd0, cnt_b}, 32'd1);

    // stall: enable low for 3 cycles between pixels
    px(1'b0, 5'b00010);
    px(1'b0, 5'b00100);
    check("stall_pre_r", {24'd0, r_a}, 32'h11);
    enable = 1'b0; iFrameStart = 1'b1; iLayerVal = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold_r", {24'd0, r_a}, 32'h11);
    end
    enable = 1'b1;
    px(1'b0, 5'b01000);
    check("stall_p2_r", {24'd0, r_a}, 32'h22);
    check("stall_cv", {31'd0, cv_a}, 32'd0);
    px(1'b0, 5'b00000);
    check("stall_p3_r", {24'd0, r_a}, 32'h33);
    px(1'b0, 5'b00000);
    check("stall_end_val", {31'd0, val_a}, 32'd0);

    // reset mid-frame with non-default config in force
    cfg_we = 1'b1; cfg_layer_en = 5'b11101; cfg_flash_mask = 5'b11111;
    px(1'b1, 5'b00000);
    cfg_we = 1'b0;
    px(1'b0, 5'b00100);
    px(1'b0, 5'b00000);
    check("pre_rst_val", {31'd0, val_a}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_val", {31'd0, val_a}, 32'd0);
    check("arst_r", {24'd0, r_a}, 32'd0);
    check("arst_cnt", {13'd0, cnt_a}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    px(1'b0, 5'b00010);
    check("post_rst_lat", {31'd0, val_a}, 32'd0);
    px(1'b0, 5'b00000);
    check("post_rst_en_val", {31'd0, val_a}, 32'd1);
    check("post_rst_en_r", {24'd0, r_a}, 32'h11);
    px(1'b1, 5'b10000);
    px(1'b1, 5'b10000);
    px(1'b1, 5'b10000);
    check("post_rst_f1", {31'd0, val_a}, 32'd1);
    px(1'b0, 5'b00000);
    check("post_rst_noflash", {31'd0, val_a}, 32'd1);
    check("post_rst_noflash_r", {24'd0, r_a}, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
